// File: rtl/gpu_irq_ctrl.sv
// rtl/gpu_irq_ctrl.sv - multi-channel GPU interrupt controller; optional hold-off timer under GPU_IRQ_HOLDOFF_EN
module gpu_irq_ctrl #(
    parameter int NCH       = 4,
    parameter int IDW       = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int HOLDOFF_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [NCH-1:0]       i_setIRQ,
    input  logic [NCH-1:0]       i_edgeMode,
    input  logic [NCH-1:0]       i_ackIRQ,
    input  logic                 i_maskWr,
    input  logic [NCH-1:0]       i_maskData,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    output logic [NCH-1:0]       o_pending,
    output logic [NCH-1:0]       o_mask,
    output logic                 o_irq,
    output logic [IDW-1:0]       o_irqId
);

    logic [NCH-1:0] prev_q;
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] pending_d;
    logic [NCH-1:0] mask_q;
    logic [NCH-1:0] mask_d;
    logic [NCH-1:0] event_d;
    logic [NCH-1:0] active;
    logic           irq_raw;
    logic [IDW-1:0] irq_id;

    // Event detection and sticky pending update; a same-cycle set beats the ack.
    always_comb begin
        event_d   = (i_edgeMode & i_setIRQ & ~prev_q) | (~i_edgeMode & i_setIRQ);
        pending_d = event_d | (pending_q & ~i_ackIRQ);
        mask_d    = i_maskWr ? i_maskData : mask_q;
    end

    // Channel state registers; prev resets low so a source high at reset release counts as an edge.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            prev_q    <= i_setIRQ;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign active  = pending_q & mask_q;
    assign irq_raw = |active;

    // Fixed priority: the lowest-index active channel wins, 0 when none is active.
    always_comb begin
        irq_id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id = IDW'(i);
            end
        end
    end

    assign o_pending = pending_q;
    assign o_mask    = mask_q;
    assign o_irqId   = irq_id;

`ifdef GPU_IRQ_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] hold_q;
    logic [HOLDOFF_W-1:0] hold_d;

    // The line is quiet while the hold-off counter runs; pending and ID keep tracking.
    assign o_irq = irq_raw & (hold_q == '0);

    // Acking a visible interrupt arms the counter; otherwise it counts down to zero.
    always_comb begin
        hold_d = hold_q;
        if ((|i_ackIRQ) && o_irq) begin
            hold_d = i_holdoff;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLDOFF_W'(1);
        end
    end

    // Hold-off counter register.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_holdoff;

    assign unused_holdoff = ^i_holdoff;
    assign o_irq          = irq_raw;
`endif

endmodule
